// File: rtl/sync_frame_pkg.sv
// Shared types and default constants for the sync-frame serializer.
// The receiver side uses the same sync pattern.
package sync_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    DATA   = 2'd2,
    PARITY = 2'd3
  } state_t;

  localparam int                      SYNC_LEN_DEF = 4;
  localparam logic [SYNC_LEN_DEF-1:0] SYNC_PAT_DEF = 4'b1010;
  localparam int                      DATA_W_DEF   = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register that emits its word MSB first.
// The current serial bit is always the register MSB.
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= '0;
    end else if (load) begin
      sr_q <= din;
    end else if (shift) begin
      sr_q <= sr_q << 1;
    end
  end

  assign msb = sr_q[W-1];

endmodule

// File: rtl/sync_frame_serializer.sv
// Serializes parallel words into frames: sync pattern, data MSB first, optional parity.
// All line outputs are registered from the next-state view, so the first sync bit follows acceptance by one cycle.
module sync_frame_serializer
  import sync_frame_pkg::*;
#(
  parameter int                  DATA_W     = DATA_W_DEF,
  parameter int                  SYNC_LEN   = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_PAT   = SYNC_PAT_DEF,
  parameter bit                  PARITY_EN  = 1'b1,
  parameter bit                  PARITY_ODD = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int MAX_LEN = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
  localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             parity_q;
  logic             last_bit;
  logic             accept;
  logic             shift_msb;
  logic             sync_bit;
  logic             data_d;
  logic             frame_done_d;

  // The cycle carrying the final frame bit doubles as an accept slot for back-to-back frames.
  assign last_bit = (state_q == PARITY) ||
                    (state_q == DATA && cnt_q == DATA_LAST && !PARITY_EN);
  assign in_ready = (state_q == IDLE) || last_bit;
  assign accept   = in_valid && in_ready;

  piso_shift_reg #(
    .W (DATA_W)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state_d == DATA),
    .din   (data_in),
    .msb   (shift_msb)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (last_bit) begin
      state_d = accept ? SYNC : IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_d = SYNC;
            cnt_d   = '0;
          end
        end
        SYNC: begin
          if (cnt_q == SYNC_LAST) begin
            state_d = DATA;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == DATA_LAST) begin
            state_d = PARITY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Line value for the bit that will be on data_out after the coming edge.
  always_comb begin
    sync_bit = 1'b0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      if (cnt_d == CNT_W'(SYNC_LEN - 1 - i)) sync_bit = SYNC_PAT[i];
    end
    case (state_d)
      SYNC:    data_d = sync_bit;
      DATA:    data_d = shift_msb;
      PARITY:  data_d = parity_q;
      default: data_d = 1'b0;
    endcase
    frame_done_d = (state_d == PARITY) ||
                   (state_d == DATA && cnt_d == DATA_LAST && !PARITY_EN);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      parity_q   <= 1'b0;
      data_out   <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out   <= data_d;
      out_valid  <= (state_d != IDLE);
      frame_done <= frame_done_d;
      if (accept) parity_q <= (^data_in) ^ PARITY_ODD;
    end
  end

endmodule

// File: tb/tb_sync_frame_serializer.sv
// Directed bench for sync_frame_serializer: default, odd-parity and no-parity instances
// share clock and reset; expected frames are written out by hand.
module tb_sync_frame_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] din [3];
  logic [2:0] vin;
  logic [2:0] rdy;
  logic [2:0] dout;
  logic [2:0] oval;
  logic [2:0] fdone;

  int n_checks;
  int n_errors;

  sync_frame_serializer dut_def (
    .clk (clk), .rst (rst), .data_in (din[0]), .in_valid (vin[0]), .in_ready (rdy[0]),
    .data_out (dout[0]), .out_valid (oval[0]), .frame_done (fdone[0])
  );

  sync_frame_serializer #(.PARITY_ODD(1'b1)) dut_odd (
    .clk (clk), .rst (rst), .data_in (din[1]), .in_valid (vin[1]), .in_ready (rdy[1]),
    .data_out (dout[1]), .out_valid (oval[1]), .frame_done (fdone[1])
  );

  sync_frame_serializer #(.PARITY_EN(1'b0)) dut_np (
    .clk (clk), .rst (rst), .data_in (din[2]), .in_valid (vin[2]), .in_ready (rdy[2]),
    .data_out (dout[2]), .out_valid (oval[2]), .frame_done (fdone[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, "_dout"}, dout[sel], 1'b0);
    check({tag, "_oval"}, oval[sel], 1'b0);
    check({tag, "_fdone"}, fdone[sel], 1'b0);
    check({tag, "_rdy"}, rdy[sel], 1'b1);
  endtask

  // Called at a negedge with the instance able to accept; checks the whole frame.
  task automatic send_frame(input int sel, input logic [7:0] word, input logic [15:0] exp,
                            input int len, input string tag);
    din[sel] = word;
    vin[sel] = 1'b1;
    for (int k = 0; k < 20 && rdy[sel] !== 1'b1; k++) @(negedge clk);
    check({tag, "_rdy"}, rdy[sel], 1'b1);
    @(negedge clk);
    vin[sel] = 1'b0;
    for (int i = 0; i < len; i++) begin
      check($sformatf("%s_bit%0d", tag, i), dout[sel], exp[len-1-i]);
      check($sformatf("%s_oval%0d", tag, i), oval[sel], 1'b1);
      check($sformatf("%s_fdone%0d", tag, i), fdone[sel], (i == len - 1));
      @(negedge clk);
    end
    check_idle(sel, {tag, "_after"});
  endtask

  // Two frames on the default instance; w2 is presented while in_ready is low.
  task automatic run_b2b(input logic [7:0] w1, input logic [7:0] w2, input logic [25:0] exp,
                         input string tag);
    din[0] = w1;
    vin[0] = 1'b1;
    check({tag, "_rdy"}, rdy[0], 1'b1);
    @(negedge clk);
    din[0] = w2;
    for (int i = 0; i < 26; i++) begin
      if (i == 13) vin[0] = 1'b0;
      check($sformatf("%s_bit%0d", tag, i), dout[0], exp[25-i]);
      check($sformatf("%s_oval%0d", tag, i), oval[0], 1'b1);
      check($sformatf("%s_fdone%0d", tag, i), fdone[0], (i == 12 || i == 25));
      check($sformatf("%s_rdy%0d", tag, i), rdy[0], (i == 12 || i == 25));
      @(negedge clk);
    end
    check_idle(0, {tag, "_after"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    vin      = '0;
    for (int s = 0; s < 3; s++) din[s] = 8'h00;

    // Reset for two cycles, then idle.
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      check_idle(0, $sformatf("reset_idle%0d", c));
      @(negedge clk);
    end

    // Single frame, even parity: A5 has four ones.
    send_frame(0, 8'hA5, 16'b1010_10100101_0, 13, "a5");

    // Odd parity: 01 has one 1-bit, so the parity bit is 0.
    send_frame(1, 8'h01, 16'b1010_00000001_0, 13, "odd01");

    // Back-to-back A5 then 3C.
    run_b2b(8'hA5, 8'h3C, {13'b1010_10100101_0, 13'b1010_00111100_0}, "b2b");

    // Backpressure: FF is presented during the 3C frame and only taken at its last bit.
    run_b2b(8'h3C, 8'hFF, {13'b1010_00111100_0, 13'b1010_11111111_0}, "bp");

    // Reset in the 6th bit cycle of a frame, with a handshake attempt during reset.
    din[0] = 8'hA5;
    vin[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_oval_before", oval[0], 1'b1);
    rst    = 1'b0;
    din[0] = 8'h5A;
    vin[0] = 1'b1;
    @(negedge clk);
    check("mid_rst_dout", dout[0], 1'b0);
    check("mid_rst_oval", oval[0], 1'b0);
    check("mid_rst_fdone", fdone[0], 1'b0);
    @(negedge clk);
    rst    = 1'b1;
    vin[0] = 1'b0;
    @(negedge clk);
    check_idle(0, "mid_rst_noaccept");
    send_frame(0, 8'h5A, 16'b1010_01011010_0, 13, "post_rst5a");

    // No parity: 12-bit frame.
    send_frame(2, 8'h5A, 16'b1010_01011010, 12, "np5a");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
